// File: rtl/bpu_pkg.sv
// Shared types and constants for the next-PC / branch prediction controller.
package bpu_pkg;

    // BTB fields are sized for the widest supported XLEN; narrower builds zero-extend.
    localparam int BPU_XLEN_MAX = 32;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'b00,
        PC_PRED     = 2'b01,
        PC_REDIRECT = 2'b10,
        PC_HOLD     = 2'b11
    } pc_sel_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                    valid;
        logic [BPU_XLEN_MAX-1:0] tag;
        logic [BPU_XLEN_MAX-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/bpu_sat_counter2.sv
// Next-value function of a 2-bit saturating branch counter (pure combinational).
module bpu_sat_counter2
    import bpu_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/bpu_pc_sel_ctrl.sv
// Next-PC select controller with direct-mapped BHT/BTB and mispredict flush.
// Define BPU_PERF_CNT_EN to add branch / mispredict performance counter ports.
module bpu_pc_sel_ctrl
    import bpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic            if_valid_i,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic [1:0]      pc_sel_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0]     perf_branches_o,
    output logic [31:0]     perf_mispred_o,
`endif
    output logic            init_busy_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    state_e           state_q;
    logic [IDX_W-1:0] init_idx_q;
    logic [1:0]       ctr_q [BHT_ENTRIES];
    btb_entry_t       btb_q [BHT_ENTRIES];

    logic             run;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    btb_entry_t       if_entry;
    logic [1:0]       if_ctr;
    logic [1:0]       ex_ctr_next;
    logic             hit;
    logic             ex_branch;
    logic             mispredict;

    assign run       = (state_q == RUN);
    assign if_idx    = if_pc_i[IDX_W+1:2];
    assign ex_idx    = ex_pc_i[IDX_W+1:2];
    assign if_entry  = btb_q[if_idx];
    assign if_ctr    = ctr_q[if_idx];
    assign ex_branch = run & ex_valid_i & ex_is_branch_i;

    // Table reads are never bypassed: a same-cycle update is seen only next cycle.
    assign hit = run & if_entry.valid & if_ctr[1]
               & (if_entry.tag == BPU_XLEN_MAX'(if_pc_i >> (IDX_W + 2)));

    assign mispredict = ex_branch & ((ex_taken_i != ex_pred_taken_i)
                      | (ex_taken_i & (ex_target_i != ex_pred_target_i)));

    bpu_sat_counter2 u_sat_counter2 (
        .ctr      (ctr_q[ex_idx]),
        .taken    (ex_taken_i),
        .ctr_next (ex_ctr_next)
    );

    always_comb begin
        pred_taken_o  = hit & if_valid_i & ~stall_i & ~mispredict;
        pred_target_o = hit ? XLEN'(if_entry.target) : '0;
        redirect_pc_o = '0;
        flush_o       = mispredict;
        init_busy_o   = ~run;
        pc_sel_o      = PC_PLUS4;
        if (mispredict)
            redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(4);
        if (!run)             pc_sel_o = PC_HOLD;
        else if (mispredict)  pc_sel_o = PC_REDIRECT;
        else if (stall_i)     pc_sel_o = PC_HOLD;
        else if (pred_taken_o) pc_sel_o = PC_PRED;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else if (state_q == INIT) begin
            init_idx_q <= init_idx_q + 1'b1;
            if (init_idx_q == IDX_W'(BHT_ENTRIES - 1)) state_q <= RUN;
        end
    end

    // NOTE: the table has no reset branch; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                ctr_q[init_idx_q]       <= WNT;
                btb_q[init_idx_q].valid <= 1'b0;
            end else if (ex_branch) begin
                ctr_q[ex_idx] <= ex_ctr_next;
                if (ex_taken_i)
                    btb_q[ex_idx] <= '{valid:  1'b1,
                                       tag:    BPU_XLEN_MAX'(ex_pc_i >> (IDX_W + 2)),
                                       target: BPU_XLEN_MAX'(ex_target_i)};
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_o <= '0;
            perf_mispred_o  <= '0;
        end else begin
            if (ex_branch)  perf_branches_o <= perf_branches_o + 32'd1;
            if (mispredict) perf_mispred_o  <= perf_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpu_pc_sel_ctrl.sv
// Self-checking bench for bpu_pc_sel_ctrl: directed plan followed by random traffic vs. a table model.
module tb_bpu_pc_sel_ctrl;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc_i;
    logic        if_valid_i;
    logic        stall_i;
    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic        ex_taken_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic [1:0]  pc_sel_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        init_busy_o;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_branches_o;
    logic [31:0] perf_mispred_o;
`endif

    bpu_pc_sel_ctrl #(.XLEN(32), .BHT_ENTRIES(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc_i          (if_pc_i),
        .if_valid_i       (if_valid_i),
        .stall_i          (stall_i),
        .ex_valid_i       (ex_valid_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_taken_i       (ex_taken_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .pc_sel_o         (pc_sel_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
`ifdef BPU_PERF_CNT_EN
        .perf_branches_o  (perf_branches_o),
        .perf_mispred_o   (perf_mispred_o),
`endif
        .init_busy_o      (init_busy_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: counters as plain integers 0..3, BTB as arrays.
    int          m_ctr   [N];
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int          init_left = 0;
    int unsigned m_branches = 0;
    int unsigned m_mispred  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input logic [31:0] ifpc, input bit ifv, input bit st,
                        input bit exv, input bit br, input bit tk, input logic [31:0] expc,
                        input logic [31:0] extgt, input bit ptk, input logic [31:0] ptgt);
        int i_if;
        int i_ex;
        bit mp;
        bit hit;
        bit pt;
        int sel;
        @(negedge clk);
        rst = r; if_pc_i = ifpc; if_valid_i = ifv; stall_i = st;
        ex_valid_i = exv; ex_is_branch_i = br; ex_taken_i = tk; ex_pc_i = expc;
        ex_target_i = extgt; ex_pred_taken_i = ptk; ex_pred_target_i = ptgt;
        #1;
        i_if = int'((ifpc >> 2) % N);
        i_ex = int'((expc >> 2) % N);
        mp   = (init_left == 0) && exv && br && ((tk != ptk) || (tk && extgt != ptgt));
        if (!r) begin
            if (init_left > 0) begin
                check("init_sel", 32'(pc_sel_o), 32'd3);
                check("init_busy", 32'(init_busy_o), 32'd1);
                check("init_flush", 32'(flush_o), 32'd0);
                check("init_pred_taken", 32'(pred_taken_o), 32'd0);
                if (init_left == N) begin
                    check("rst_pred_target", pred_target_o, 32'd0);
                    check("rst_redirect", redirect_pc_o, 32'd0);
                end
            end else begin
                hit = m_valid[i_if] && (m_tag[i_if] == (ifpc >> 6)) && (m_ctr[i_if] >= 2);
                pt  = hit && ifv && !st && !mp;
                sel = mp ? 2 : st ? 3 : pt ? 1 : 0;
                check("sel", 32'(pc_sel_o), 32'(sel));
                check("busy", 32'(init_busy_o), 32'd0);
                check("flush", 32'(flush_o), 32'(mp));
                check("pred_taken", 32'(pred_taken_o), 32'(pt));
                check("pred_target", pred_target_o, hit ? m_tgt[i_if] : 32'd0);
                check("redirect", redirect_pc_o, !mp ? 32'd0 : tk ? extgt : expc + 32'd4);
            end
`ifdef BPU_PERF_CNT_EN
            check("perf_branches", perf_branches_o, m_branches);
            check("perf_mispred", perf_mispred_o, m_mispred);
`endif
        end
        if (r) begin
            init_left = N; m_branches = 0; m_mispred = 0;
            for (int k = 0; k < N; k++) begin m_ctr[k] = 1; m_valid[k] = 0; end
        end else if (init_left > 0) begin
            init_left--;
        end else if (exv && br) begin
            m_branches++;
            if (mp) m_mispred++;
            m_ctr[i_ex] = tk ? ((m_ctr[i_ex] < 3) ? m_ctr[i_ex] + 1 : 3)
                             : ((m_ctr[i_ex] > 0) ? m_ctr[i_ex] - 1 : 0);
            if (tk) begin
                m_valid[i_ex] = 1; m_tag[i_ex] = expc >> 6; m_tgt[i_ex] = extgt;
            end
        end
    endtask

    task automatic idle(input bit r);
        step(r, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc, input bit st);
        step(0, pc, 1, st, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                           input bit ptk, input logic [31:0] ptgt, input logic [31:0] ifpc,
                           input bit st);
        step(0, ifpc, 1, st, 1, 1, tk, pc, tgt, ptk, ptgt);
    endtask

    initial begin
        // Power-up reset and full INIT sweep, then first RUN fetch.
        idle(1);
        repeat (N) idle(0);
        fetch(32'h100, 0);

        // Train 0x100 taken twice (both mispredicted), then predict it.
        resolve(32'h100, 32'h200, 1, 0, 32'h0, 32'h100, 0);
        resolve(32'h100, 32'h200, 1, 0, 32'h0, 32'h100, 0);
        fetch(32'h100, 0);

        // Predicted taken but not taken, then drive the counter to the floor.
        resolve(32'h100, 32'h200, 0, 1, 32'h200, 32'h0, 0);
        repeat (4) resolve(32'h100, 32'h200, 0, 0, 32'h0, 32'h100, 0);
        fetch(32'h100, 0);

        // Retrain, then stall interactions and aliasing.
        repeat (2) resolve(32'h100, 32'h200, 1, 1, 32'h200, 32'h0, 0);
        resolve(32'h184, 32'h300, 1, 0, 32'h0, 32'h100, 1);
        fetch(32'h100, 1);
        fetch(32'h140, 0);
        fetch(32'h100, 0);

        // Reset during INIT restarts the sweep.
        idle(1);
        repeat (7) idle(0);
        idle(1);
        repeat (N) idle(0);
        fetch(32'h100, 0);

        // Three branches, one of them mispredicted.
        resolve(32'h108, 32'h400, 0, 0, 32'h0, 32'h0, 0);
        resolve(32'h10c, 32'h500, 1, 0, 32'h0, 32'h0, 0);
        resolve(32'h110, 32'h600, 0, 0, 32'h0, 32'h0, 0);
        idle(0);

        // Randomised traffic over a small PC window with aliases.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] pc;
            logic [31:0] fpc;
            logic [31:0] tgt;
            bit          tk;
            pc  = 32'h100 + 32'(4 * $urandom_range(0, 23)) + (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h0);
            fpc = 32'h100 + 32'(4 * $urandom_range(0, 23)) + (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h0);
            tgt = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            tk  = bit'($urandom_range(0, 1));
            step($urandom_range(0, 299) == 0, fpc, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 tk, pc, tgt, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 0) ? tgt : 32'h1000 + 32'(4 * $urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
